muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with its own HI/LO register pair, for the EXE stage.
//  Accepts one op per valid/ready handshake and computes signed or unsigned multiply/divide.
//  Supports cancel on pipeline flush and defines results for divide-by-zero and signed overflow.
//  EXE stalls (EXE_over low) while busy; HI/LO read ports feed MFHI/MFLO forwarding.
// PARAMETERS
//  WIDTH      32  operand width; HI and LO are each WIDTH bits; even and >= 8
//  CNT_W      $clog2(WIDTH)+1  iteration counter width (derived, not overridable)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  resetn     in   1      asynchronous active-low reset
//  op_valid   in   1      op request
//  op_ready   out  1      unit can accept; high only in IDLE
//  op_code    in   4      MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5; MADD=8 MADDU=9 MSUB=10 MSUBU=11 (ACC only)
//  op_a       in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
//  op_b       in   WIDTH  rt operand (divisor / multiplier)
//  cancel     in   1      flush: abort in-flight op, HI/LO untouched
//  busy       out  1      op in flight (state != IDLE)
//  res_valid  out  1      one-cycle pulse; HI/LO updated on the same edge
//  div_zero   out  1      pulses with res_valid when DIV/DIVU had op_b==0
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=lo=0, res_valid=0, div_zero=0, busy=0, op_ready=1, FSM=IDLE. Async assert, sync deassert.
//  Accept: op_valid & op_ready & ~cancel at an edge; operands latched; op_a/op_b may change afterwards.
//  FSM: IDLE -> MUL|DIV (iterate) -> FIX (sign correction, accumulate) -> IDLE; res_valid pulses on the FIX->IDLE edge.
//  MTHI/MTLO: IDLE -> IDLE; res_valid and the write on the edge after acceptance; the other register is unchanged.
//  Latency from accept edge to res_valid: MUL* = WIDTH+1 cycles, DIV* = WIDTH+1, MTHI/MTLO = 1.
//  Multiply: radix-2 shift-add on magnitudes; signed ops negate the 2*WIDTH product if the sign bits differ.
//    Result: {hi,lo} = product.
//  Divide: restoring, one quotient bit per cycle on magnitudes.
//    Quotient is negated iff the operand signs differ; remainder takes the dividend's sign.
//    Result: lo = quotient, hi = remainder.
//  Divide by zero: no iteration. FIX follows the accept edge (latency 2).
//    Result: lo = all-ones, hi = op_a, div_zero=1.
//  Signed overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0; no flag.
//  Cancel: highest priority in any state. FSM goes to IDLE on the next edge; no res_valid, no HI/LO write.
//    Cancel in the accept cycle drops the op.
//  Unknown or disabled op_code: accepted as a NOP; res_valid after 1 cycle; HI/LO unchanged.
//  op_ready is low in IDLE during the res_valid cycle. Back-to-back accept starts the cycle after IDLE.
// CONFIGURATION
//  MULDIV_ACC_EN defined: MADD/MADDU/MSUB/MSUBU enabled.
//    FIX computes {hi,lo} = {hi,lo} +/- product, modulo 2^(2W); latency WIDTH+1.
//  MULDIV_ACC_EN undefined: codes 8-11 are NOPs per the unknown-code rule; no 2W adder is instantiated.
// STRUCTURE
//  Shared package muldiv_defs: op_code localparams, FSM state encoding (IDLE/MUL/DIV/FIX), is_signed/is_div decode helpers.
//  Sub-module div_iter: restoring-divide datapath (remainder/quotient shift registers, one step per enable).
//    The multiplier stays inline in muldiv_unit.
// TESTING
//  MULT 0xFFFFFFFE * 0x00000003 -> res_valid at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU same -> lo=0x7FFFFFFC, hi=1.
//  DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1 at cycle 2.
//  MULTU start, cancel at cycle 10 -> no res_valid, hi/lo retain prior values, op_ready=1 at cycle 11.
//  MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi=0x1234, lo=0x5678; resetn low mid-DIV -> all outputs reset at once.
//  ACC_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0; without macro same stimulus -> unchanged, res_valid at cycle 1.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and op-class decode helpers.
package muldiv_defs;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Handshake, cancel and HI/LO result bundle between the EXE stage (master)
// and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cancel;
  logic             busy;
  logic             res_valid;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b, cancel,
    input  op_ready, busy, res_valid, div_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, cancel,
    output op_ready, busy, res_valid, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per
// enabled step, WIDTH steps per division.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   trial;

  // The partial remainder stays below the divisor, so a borrow into bit WIDTH
  // means the trial subtraction went negative and must be restored.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with its own HI/LO pair for the EXE stage.
// Define MULDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module muldiv_unit
  import muldiv_defs::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             next_state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   a_in_mag;
  logic [WIDTH-1:0]   b_in_mag;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               mt_pend;
  logic               res_valid_q;
  logic               div_zero_q;
  logic               accept;
  logic               start_mul;
  logic               start_div;
  logic               b_zero;
  logic               last_iter;
  logic               ready;
  logic               busy;
  logic               mul_step;
  logic               div_step;
  logic               fix_write;

  assign accept    = bus.op_valid & ready & ~bus.cancel;
  assign start_div = is_div(bus.op_code);
`ifdef MULDIV_ACC_EN
  assign start_mul = is_mul(bus.op_code) | is_acc(bus.op_code);
`else
  assign start_mul = is_mul(bus.op_code);
`endif
  assign b_zero    = (b_q == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign a_in_mag = (is_signed(bus.op_code) && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign b_in_mag = (is_signed(bus.op_code) && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign a_mag    = (is_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.cancel) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && start_mul)      next_state = ST_MUL;
          else if (accept && start_div) next_state = ST_DIV;
        end
        ST_MUL:  if (last_iter)           next_state = ST_FIX;
        // A zero divisor skips iteration and goes straight to the fix-up cycle.
        ST_DIV:  if (b_zero || last_iter) next_state = ST_FIX;
        ST_FIX:  next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready     = (state == ST_IDLE) & ~mt_pend & ~res_valid_q;
    busy      = (state != ST_IDLE);
    mul_step  = (state == ST_MUL) & ~bus.cancel;
    div_step  = (state == ST_DIV) & ~b_zero & ~bus.cancel;
    fix_write = (state == ST_FIX) & ~bus.cancel;
  end

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
  assign prod_fix = (is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod : prod;
  assign quo_fix  = (is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo : quo;
  assign rem_fix  = (is_signed(op_q) && a_q[WIDTH-1]) ? -rem : rem;

`ifdef MULDIV_ACC_EN
  logic [2*WIDTH-1:0] acc_sum;
  assign acc_sum = is_sub(op_q) ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
`endif

  always_comb begin
    fix_hi = hi_q;
    fix_lo = lo_q;
    if (is_div(op_q)) begin
      if (b_zero) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
`ifdef MULDIV_ACC_EN
    else if (is_acc(op_q)) begin
      {fix_hi, fix_lo} = acc_sum;
    end
`endif
    else begin
      {fix_hi, fix_lo} = prod_fix;
    end
  end

  // MTHI/MTLO and NOP codes never leave IDLE; mt_pend holds them for the one
  // cycle before their write/pulse so the latency matches the other ops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      prod        <= '0;
      mt_pend     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      if (accept) begin
        op_q    <= bus.op_code;
        a_q     <= bus.op_a;
        b_q     <= bus.op_b;
        cnt     <= '0;
        prod    <= {{WIDTH{1'b0}}, b_in_mag};
        mt_pend <= ~start_mul & ~start_div;
      end else if (mt_pend) begin
        mt_pend <= 1'b0;
        if (!bus.cancel) begin
          res_valid_q <= 1'b1;
          if (op_q == OP_MTHI) hi_q <= a_q;
          if (op_q == OP_MTLO) lo_q <= a_q;
        end
      end
      if (mul_step) begin
        prod <= {mul_sum, prod[WIDTH-1:1]};
        cnt  <= cnt + CNT_W'(1);
      end
      if (div_step) cnt <= cnt + CNT_W'(1);
      if (fix_write) begin
        hi_q        <= fix_hi;
        lo_q        <= fix_lo;
        res_valid_q <= 1'b1;
        div_zero_q  <= is_div(op_q) & b_zero;
      end
    end
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept & start_div),
    .step      (div_step),
    .dividend  (a_in_mag),
    .divisor   (b_in_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  assign bus.op_ready  = ready;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
